// File: rtl/multi_vc_fifo_pkg.sv
// Shared helpers for the multi-channel FIFO: width calculations and error-flag indices.
package multi_vc_fifo_pkg;

    // Bits needed to address NUM_VC channels (at least one bit).
    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    // Occupancy counter width: must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Positions of the sticky error flags inside the error register.
    localparam int ERR_W         = 2;
    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Per-VC bookkeeping: read/write pointers, occupancy and registered status flags.
module vc_fifo_ctrl
    import multi_vc_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = 2,
    parameter int AFULL_THRESH = 3,
    localparam int CNT_W       = cnt_width(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_acc,
    input  logic                  rd_acc,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full
);

    localparam int              DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(AFULL_THRESH);

    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]      count_d, count_q;
    logic                  empty_d, empty_q;
    logic                  full_d, full_q;
    logic                  afull_d, afull_q;

    // Next pointers, occupancy and flags; flags are taken from the next count so they stay registered.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == CNT_W'(0));
        full_d  = (count_d == DEPTH_C);
        afull_d = (count_d >= THRESH_C);
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
        end
    end

    assign wr_ptr      = wr_ptr_q;
    assign rd_ptr      = rd_ptr_q;
    assign count       = count_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = afull_q;

endmodule

// File: rtl/multi_vc_fifo.sv
// Multi-VC synchronous FIFO: shared storage, one write port and one read port, per-VC control.
module multi_vc_fifo
    import multi_vc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 2,
    parameter int NUM_VC       = 4,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 1,
    localparam int VC_W        = vc_width(NUM_VC),
    localparam int CNT_W       = cnt_width(ADDR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [VC_W-1:0]         wr_vc,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    rd_en,
    input  logic [VC_W-1:0]         rd_vc,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       almost_full,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic                    err_overflow,
    output logic                    err_underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [NUM_VC-1:0]     empty_s, full_s, afull_s;
    logic [NUM_VC-1:0]     wr_sel_s, rd_sel_s;
    logic [NUM_VC-1:0]     wr_acc_s, rd_acc_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_s [NUM_VC];
    logic [ADDR_WIDTH-1:0] rd_ptr_s [NUM_VC];
    logic [CNT_W-1:0]      count_s  [NUM_VC];
    logic                  wr_accept_s, rd_accept_s, same_vc_s;
    logic [DATA_WIDTH-1:0] rd_data_s;

    logic [DATA_WIDTH-1:0] mem_q [NUM_VC][DEPTH];

    logic [DATA_WIDTH-1:0] dout_d, dout_q;
    logic                  dout_valid_d, dout_valid_q;
    logic [ERR_W-1:0]      err_d, err_q;

    // Decode VC selects and accept strobes; out-of-range VCs select nothing and are never accepted.
    always_comb begin
        wr_sel_s = '0;
        rd_sel_s = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel_s[v] = (wr_vc == VC_W'(v));
            rd_sel_s[v] = (rd_vc == VC_W'(v));
        end
        rd_accept_s = rd_en && (|(rd_sel_s & ~empty_s));
        same_vc_s   = |(rd_sel_s & wr_sel_s);
        // A full VC still takes a write when the same VC is popped this cycle.
        wr_accept_s = wr_en && (|(wr_sel_s & (~full_s | {NUM_VC{rd_accept_s && same_vc_s}})));
        wr_acc_s    = wr_sel_s & {NUM_VC{wr_accept_s}};
        rd_acc_s    = rd_sel_s & {NUM_VC{rd_accept_s}};
    end

    // One-hot read mux over the VC being popped.
    always_comb begin
        rd_data_s = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            rd_data_s = rd_data_s | ({DATA_WIDTH{rd_acc_s[v]}} & mem_q[v][rd_ptr_s[v]]);
        end
    end

    // Next read register and sticky error flags.
    always_comb begin
        dout_valid_d = rd_accept_s;
        if (rd_accept_s) begin
            dout_d = rd_data_s;
        end else begin
            dout_d = dout_q;
        end
        err_d                = err_q;
        err_d[ERR_OVERFLOW]  = err_q[ERR_OVERFLOW]  | (wr_en && !wr_accept_s);
        err_d[ERR_UNDERFLOW] = err_q[ERR_UNDERFLOW] | (rd_en && !rd_accept_s);
    end

    // Output and error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= '0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (!rst && wr_acc_s[v]) begin
                mem_q[v][wr_ptr_s[v]] <= din;
            end
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo_ctrl #(
            .ADDR_WIDTH   (ADDR_WIDTH),
            .AFULL_THRESH (AFULL_THRESH)
        ) u_ctrl (
            .clk         (clk),
            .rst         (rst),
            .wr_acc      (wr_acc_s[g]),
            .rd_acc      (rd_acc_s[g]),
            .wr_ptr      (wr_ptr_s[g]),
            .rd_ptr      (rd_ptr_s[g]),
            .count       (count_s[g]),
            .empty       (empty_s[g]),
            .full        (full_s[g]),
            .almost_full (afull_s[g])
        );
        assign count[g*CNT_W +: CNT_W] = count_s[g];
    end

    assign empty         = empty_s;
    assign full          = full_s;
    assign almost_full   = afull_s;
    assign dout          = dout_q;
    assign dout_valid    = dout_valid_q;
    assign err_overflow  = err_q[ERR_OVERFLOW];
    assign err_underflow = err_q[ERR_UNDERFLOW];

endmodule

// File: tb/tb_multi_vc_fifo.sv
// Self-checking bench for multi_vc_fifo: queue-based reference model plus directed and random traffic.
module tb_multi_vc_fifo;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int NV    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int AFT   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_vc = 2'd0;
    logic [DW-1:0] din = 8'd0;
    logic          rd_en = 1'b0;
    logic [1:0]    rd_vc = 2'd0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic [NV-1:0] empty, full, almost_full;
    logic [NV*CW-1:0] count;
    logic          err_overflow, err_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per VC plus the read register and sticky flags.
    logic [DW-1:0] mq [NV][$];
    logic [DW-1:0] m_dout = 8'd0;
    logic          m_dv = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    always #5 clk = ~clk;

    multi_vc_fifo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .NUM_VC       (NV),
        .AFULL_THRESH (AFT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_vc         (wr_vc),
        .din           (din),
        .rd_en         (rd_en),
        .rd_vc         (rd_vc),
        .dout          (dout),
        .dout_valid    (dout_valid),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .count         (count),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt(input int v);
        return 32'(count[v*CW +: CW]);
    endfunction

    // Advance the model by one clock edge given this cycle's inputs.
    task automatic model_step(input logic r, input logic we, input int wv, input logic [DW-1:0] d,
                              input logic re, input int rv);
        logic rok, wok;
        if (r) begin
            for (int v = 0; v < NV; v++) mq[v].delete();
            m_dout = 8'd0;
            m_dv   = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            rok = re && (rv < NV) && (mq[rv].size() > 0);
            wok = we && (wv < NV) && ((mq[wv].size() < DEPTH) || (rok && rv == wv));
            if (rok) begin
                m_dout = mq[rv].pop_front();
                m_dv   = 1'b1;
            end else begin
                m_dv = 1'b0;
            end
            if (wok) mq[wv].push_back(d);
            if (we && !wok) m_ovf = 1'b1;
            if (re && !rok) m_unf = 1'b1;
        end
    endtask

    // Compare every DUT output with the model.
    task automatic check_model();
        logic [NV-1:0]    e_empty, e_full, e_afull;
        logic [NV*CW-1:0] e_count;
        for (int v = 0; v < NV; v++) begin
            e_empty[v]          = (mq[v].size() == 0);
            e_full[v]           = (mq[v].size() == DEPTH);
            e_afull[v]          = (mq[v].size() >= AFT);
            e_count[v*CW +: CW] = CW'(mq[v].size());
        end
        chk("empty", 32'(empty), 32'(e_empty));
        chk("full", 32'(full), 32'(e_full));
        chk("almost_full", 32'(almost_full), 32'(e_afull));
        chk("count", 32'(count), 32'(e_count));
        chk("dout_valid", 32'(dout_valid), 32'(m_dv));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
        chk("err_underflow", 32'(err_underflow), 32'(m_unf));
    endtask

    // Drive one cycle, step the model, then check just after the edge.
    task automatic cycle(input logic r, input logic we, input int wv, input logic [DW-1:0] d,
                         input logic re, input int rv);
        rst   = r;
        wr_en = we;
        wr_vc = 2'(wv);
        din   = d;
        rd_en = re;
        rd_vc = 2'(rv);
        model_step(r, we, wv, d, re, rv);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic wr(input int v, input logic [DW-1:0] d);
        cycle(1'b0, 1'b1, v, d, 1'b0, 0);
    endtask

    task automatic rd(input int v);
        cycle(1'b0, 1'b0, 0, 8'd0, 1'b1, v);
    endtask

    initial begin
        logic [DW-1:0] exp_d [4];

        // Reset then idle
        cycle(1'b1, 1'b0, 0, 8'd0, 1'b0, 0);
        cycle(1'b1, 1'b0, 0, 8'd0, 1'b0, 0);
        cycle(1'b0, 1'b0, 0, 8'd0, 1'b0, 0);
        chk("rst_empty", 32'(empty), 32'h0000_000F);
        chk("rst_count", 32'(count), 32'h0000_0000);
        chk("rst_dv", 32'(dout_valid), 32'h0000_0000);

        // VC2 fill and drain in order
        for (int i = 0; i < 4; i++) wr(2, 8'hA0 + 8'(i));
        chk("vc2_full", 32'(full[2]), 32'h1);
        chk("others_empty", 32'(empty & 4'b1011), 32'h0000_000B);
        for (int i = 0; i < 4; i++) begin
            rd(2);
            chk("vc2_dout", 32'(dout), 32'(8'hA0 + 8'(i)));
            chk("vc2_dv", 32'(dout_valid), 32'h1);
        end
        chk("vc2_empty", 32'(empty[2]), 32'h1);

        // VC1 overflow, then same-VC read+write on a full queue
        for (int i = 0; i < 4; i++) wr(1, 8'h10 + 8'(i));
        wr(1, 8'h55);
        chk("ovf_flag", 32'(err_overflow), 32'h1);
        chk("ovf_cnt1", cnt(1), 32'h4);
        cycle(1'b0, 1'b1, 1, 8'h66, 1'b1, 1);
        chk("rw_full_dout", 32'(dout), 32'h10);
        chk("rw_full_cnt1", cnt(1), 32'h4);
        exp_d = '{8'h11, 8'h12, 8'h13, 8'h66};
        for (int i = 0; i < 4; i++) begin
            rd(1);
            chk("vc1_drain", 32'(dout), 32'(exp_d[i]));
        end

        // Empty VC0: read not rescued by same-cycle write
        cycle(1'b0, 1'b1, 0, 8'h77, 1'b1, 0);
        chk("unf_flag", 32'(err_underflow), 32'h1);
        chk("unf_dv", 32'(dout_valid), 32'h0);
        chk("unf_cnt0", cnt(0), 32'h1);
        rd(0);
        chk("vc0_77", 32'(dout), 32'h77);

        // VC0/VC3 interleave with pointer wrap
        for (int k = 0; k < 3; k++) begin
            wr(0, 8'hC0 + 8'(k));
            wr(3, 8'hD0 + 8'(k));
        end
        chk("afull0", 32'(almost_full[0]), 32'h1);
        for (int k = 0; k < 3; k++) begin
            rd(0);
            chk("wrap0a", 32'(dout), 32'(8'hC0 + 8'(k)));
            rd(3);
            chk("wrap3a", 32'(dout), 32'(8'hD0 + 8'(k)));
        end
        for (int k = 3; k < 6; k++) begin
            wr(0, 8'hC0 + 8'(k));
            wr(3, 8'hD0 + 8'(k));
        end
        for (int k = 3; k < 6; k++) begin
            rd(3);
            chk("wrap3b", 32'(dout), 32'(8'hD0 + 8'(k)));
            rd(0);
            chk("wrap0b", 32'(dout), 32'(8'hC0 + 8'(k)));
        end

        // Reset mid-stream with a read requested in the same cycle
        for (int k = 0; k < 3; k++) wr(2, 8'hE0 + 8'(k));
        chk("pre_rst_cnt2", cnt(2), 32'h3);
        cycle(1'b1, 1'b1, 2, 8'hFF, 1'b1, 2);
        chk("post_rst_count", 32'(count), 32'h0);
        chk("post_rst_dv", 32'(dout_valid), 32'h0);
        chk("post_rst_err", 32'({err_overflow, err_underflow}), 32'h0);
        wr(2, 8'h99);
        rd(2);
        chk("post_rst_data", 32'(dout), 32'h99);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)), 8'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, NV - 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
